// File: rtl/sram_ctrl.sv
// Word-to-halfword controller for a 256Kx16 asynchronous SRAM with setup/strobe/hold phasing.
// Optional SRAM_CTRL_HALFSKIP_EN skips a half-word phase whose two byte enables are both zero.
module sram_ctrl #(
  parameter int unsigned STROBE_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [16:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [17:0] sram_addr,
  inout  wire  [15:0] sram_dq,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        sram_ce_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  localparam int unsigned CntW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(STROBE_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoSetup,
    StLoStrobe,
    StLoHold,
    StHiSetup,
    StHiStrobe,
    StHiHold
  } state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [CntW-1:0]   r_cnt;
  logic [CntW-1:0]   w_cnt_next;
  logic              r_we;
  logic [16:0]       r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic              r_hi_en;
  logic [15:0]       r_rd_lo;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;

  logic              w_accept;
  logic              w_lo_en_in;
  logic              w_hi_en_in;
  logic              w_strobe_done;
  logic              w_rsp_fire;
  logic [31:0]       w_rsp_data;
  logic [15:0]       w_cap_lo;
  logic [15:0]       w_cap_hi;
  logic              w_lo_phase;
  logic              w_hi_phase;
  logic              w_in_strobe;
  logic              w_dq_oe;
  logic [15:0]       w_dq_out;

`ifdef SRAM_CTRL_HALFSKIP_EN
  assign w_lo_en_in = |req_be[1:0];
  assign w_hi_en_in = |req_be[3:2];
`else
  assign w_lo_en_in = 1'b1;
  assign w_hi_en_in = 1'b1;
`endif

  assign req_ready     = (r_state == StIdle) && !reset;
  assign w_accept      = req_valid && req_ready;
  assign w_strobe_done = (r_cnt == '0);
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;

  // Disabled byte lanes and write cycles return zero rather than bus contents.
  assign w_cap_lo = r_we ? 16'h0000 :
                    {sram_dq[15:8] & {8{r_be[1]}}, sram_dq[7:0] & {8{r_be[0]}}};
  assign w_cap_hi = r_we ? 16'h0000 :
                    {sram_dq[15:8] & {8{r_be[3]}}, sram_dq[7:0] & {8{r_be[2]}}};

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_rsp_fire   = 1'b0;
    w_rsp_data   = r_rsp_rdata;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (w_lo_en_in) begin
            w_state_next = StLoSetup;
          end else if (w_hi_en_in) begin
            w_state_next = StHiSetup;
          end else begin
            // Nothing enabled: respond at once with the HI_HOLD cycle kept inactive.
            w_state_next = StHiHold;
            w_rsp_fire   = 1'b1;
            w_rsp_data   = 32'h0000_0000;
          end
        end
      end
      StLoSetup: begin
        w_state_next = StLoStrobe;
        w_cnt_next   = CntLoad;
      end
      StLoStrobe: begin
        if (w_strobe_done) begin
          w_state_next = StLoHold;
          if (!r_hi_en) begin
            w_rsp_fire = 1'b1;
            w_rsp_data = {16'h0000, w_cap_lo};
          end
        end else begin
          w_cnt_next = r_cnt - CntW'(1);
        end
      end
      StLoHold: begin
        w_state_next = r_hi_en ? StHiSetup : StIdle;
      end
      StHiSetup: begin
        w_state_next = StHiStrobe;
        w_cnt_next   = CntLoad;
      end
      StHiStrobe: begin
        if (w_strobe_done) begin
          w_state_next = StHiHold;
          w_rsp_fire   = 1'b1;
          w_rsp_data   = {w_cap_hi, r_rd_lo};
        end else begin
          w_cnt_next = r_cnt - CntW'(1);
        end
      end
      StHiHold: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_hi_en     <= 1'b0;
      r_rd_lo     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_rsp_valid <= w_rsp_fire;
      if (w_rsp_fire) begin
        r_rsp_rdata <= w_rsp_data;
      end
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_be    <= req_be;
        r_wdata <= req_wdata;
        r_hi_en <= w_hi_en_in;
        r_rd_lo <= '0;
      end else if ((r_state == StLoStrobe) && w_strobe_done) begin
        r_rd_lo <= w_cap_lo;
      end
    end
  end

  assign w_lo_phase  = (r_state == StLoSetup) || (r_state == StLoStrobe) ||
                       (r_state == StLoHold);
  assign w_hi_phase  = ((r_state == StHiSetup) || (r_state == StHiStrobe) ||
                        (r_state == StHiHold)) && r_hi_en;
  assign w_in_strobe = (r_state == StLoStrobe) || (r_state == StHiStrobe);

  always_comb begin
    sram_addr = '0;
    sram_we_n = 1'b1;
    sram_oe_n = 1'b1;
    sram_ce_n = 1'b1;
    sram_ub_n = 1'b1;
    sram_lb_n = 1'b1;
    w_dq_oe   = 1'b0;
    w_dq_out  = 16'h0000;
    if (w_lo_phase) begin
      sram_ce_n = 1'b0;
      sram_addr = {r_addr, 1'b0};
      sram_lb_n = ~r_be[0];
      sram_ub_n = ~r_be[1];
      w_dq_out  = r_wdata[15:0];
      w_dq_oe   = r_we;
    end else if (w_hi_phase) begin
      sram_ce_n = 1'b0;
      sram_addr = {r_addr, 1'b1};
      sram_lb_n = ~r_be[2];
      sram_ub_n = ~r_be[3];
      w_dq_out  = r_wdata[31:16];
      w_dq_oe   = r_we;
    end
    // Setup and hold cycles keep both strobes high so only one edge moves at a time.
    if (w_in_strobe) begin
      sram_we_n = ~r_we;
      sram_oe_n = r_we;
    end
  end

  assign sram_dq = w_dq_oe ? w_dq_out : 16'hzzzz;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: default strobe instance plus a STROBE_CYCLES=3 instance,
// each with its own behavioural asynchronous SRAM.
module tb_sram_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        req_valid;
  logic        req_valid3;
  logic        req_we;
  logic [16:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;

  logic        req_ready, rsp_valid;
  logic [31:0] rsp_rdata;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

  logic        req_ready3, rsp_valid3;
  logic [31:0] rsp_rdata3;
  logic [17:0] sram_addr3;
  wire  [15:0] sram_dq3;
  logic        sram_we_n3, sram_oe_n3, sram_ce_n3, sram_ub_n3, sram_lb_n3;

  sram_ctrl #(.STROBE_CYCLES(1)) u_dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .sram_addr (sram_addr),
    .sram_dq   (sram_dq),
    .sram_we_n (sram_we_n),
    .sram_oe_n (sram_oe_n),
    .sram_ce_n (sram_ce_n),
    .sram_ub_n (sram_ub_n),
    .sram_lb_n (sram_lb_n)
  );

  sram_ctrl #(.STROBE_CYCLES(3)) u_dut3 (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid3),
    .req_ready (req_ready3),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid3),
    .rsp_rdata (rsp_rdata3),
    .sram_addr (sram_addr3),
    .sram_dq   (sram_dq3),
    .sram_we_n (sram_we_n3),
    .sram_oe_n (sram_oe_n3),
    .sram_ce_n (sram_ce_n3),
    .sram_ub_n (sram_ub_n3),
    .sram_lb_n (sram_lb_n3)
  );

  // Behavioural SRAMs: drive on OE, write enabled lanes while WE is low.
  logic [15:0] mem  [0:1023];
  logic [15:0] mem3 [0:1023];

  assign sram_dq  = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr[9:0]] : 16'hzzzz;
  assign sram_dq3 = (!sram_ce_n3 && !sram_oe_n3 && sram_we_n3) ?
                    mem3[sram_addr3[9:0]] : 16'hzzzz;

  always @(negedge clock) begin
    if (!sram_ce_n && !sram_we_n) begin
      if (!sram_lb_n) mem[sram_addr[9:0]][7:0] <= sram_dq[7:0];
      if (!sram_ub_n) mem[sram_addr[9:0]][15:8] <= sram_dq[15:8];
    end
    if (!sram_ce_n3 && !sram_we_n3) begin
      if (!sram_lb_n3) mem3[sram_addr3[9:0]][7:0] <= sram_dq3[7:0];
      if (!sram_ub_n3) mem3[sram_addr3[9:0]][15:8] <= sram_dq3[15:8];
    end
  end

  int both_low, we_low, lo_ce, lane_bad, we3_low, we3_falls, stab3_bad;
  bit          p_we3, p_oe3;
  logic [17:0] p_addr3;
  logic [15:0] p_dq3;

  always @(negedge clock) begin
    both_low <= both_low + ((!sram_oe_n && !sram_we_n) ? 1 : 0) +
                ((!sram_oe_n3 && !sram_we_n3) ? 1 : 0);
    if (!sram_we_n) we_low <= we_low + 1;
    if (!sram_ce_n && !sram_addr[0]) lo_ce <= lo_ce + 1;
    if (!sram_we_n && ({sram_ub_n, sram_lb_n} != 2'b10)) lane_bad <= lane_bad + 1;
    if (!sram_we_n3) we3_low <= we3_low + 1;
    if (!reset) begin
      if (p_we3 && !sram_we_n3) we3_falls <= we3_falls + 1;
      if (((p_we3 != sram_we_n3) || (p_oe3 != sram_oe_n3)) &&
          ((sram_addr3 != p_addr3) || ((p_we3 != sram_we_n3) && (sram_dq3 !== p_dq3))))
        stab3_bad <= stab3_bad + 1;
    end
    p_we3   <= sram_we_n3;
    p_oe3   <= sram_oe_n3;
    p_addr3 <= sram_addr3;
    p_dq3   <= sram_dq3;
  end

  int checks;
  int failures;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request on the chosen instance; return the response cycle (-1 on timeout).
  task automatic run_req(input bit sel, input bit we, input logic [16:0] a, input logic [3:0] be,
                         input logic [31:0] wd, output int cyc, output logic [31:0] rd);
    @(posedge clock); #1;
    req_we    = we;
    req_addr  = a;
    req_be    = be;
    req_wdata = wd;
    if (sel) req_valid3 = 1'b1;
    else     req_valid  = 1'b1;
    @(posedge clock); #1;
    req_valid  = 1'b0;
    req_valid3 = 1'b0;
    cyc = -1;
    rd  = '0;
    for (int c = 1; c <= 40; c++) begin
      if ((sel ? rsp_valid3 : rsp_valid) === 1'b1) begin
        cyc = c;
        rd  = sel ? rsp_rdata3 : rsp_rdata;
        break;
      end
      @(posedge clock); #1;
    end
    if (cyc > 0) begin
      @(posedge clock); #1;
      check("rsp_pulse_ends", {63'd0, sel ? rsp_valid3 : rsp_valid}, 64'd0);
      check("ready_after_rsp", {63'd0, sel ? req_ready3 : req_ready}, 64'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    logic [31:0] rd;
    int          s1, s2, rv;
    int          acc[$];

    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_valid3 = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_be     = '0;
    req_wdata  = '0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset_ready", {63'd0, req_ready}, 64'd0);
    check("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("reset_rdata", {32'd0, rsp_rdata}, 64'd0);
    check("reset_strobes", {59'd0, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n},
          64'h1f);
    check("reset_addr", {46'd0, sram_addr}, 64'd0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", {63'd0, req_ready}, 64'd1);
    check("ready3_after_reset", {63'd0, req_ready3}, 64'd1);

    // Full word write then read
    run_req(0, 1'b1, 17'h00010, 4'b1111, 32'hDEADBEEF, cyc, rd);
    check("wr1_cycle", cyc, 64'd6);
    check("wr1_mem_lo", {48'd0, mem[32]}, 64'hBEEF);
    check("wr1_mem_hi", {48'd0, mem[33]}, 64'hDEAD);
    run_req(0, 1'b0, 17'h00010, 4'b1111, 32'h0, cyc, rd);
    check("rd1_cycle", cyc, 64'd6);
    check("rd1_data", {32'd0, rd}, 64'hDEADBEEF);

    // Partial byte-enable write over a preloaded word
    run_req(0, 1'b1, 17'h00020, 4'b1111, 32'hFFFFFFFF, cyc, rd);
    check("pre_cycle", cyc, 64'd6);
    s1 = lane_bad;
    s2 = we_low;
    run_req(0, 1'b1, 17'h00020, 4'b0101, 32'h11223344, cyc, rd);
    check("be0101_lanes", lane_bad - s1, 64'd0);
    check("be0101_we_cycles", we_low - s2, 64'd2);
    check("be0101_mem_lo", {48'd0, mem[64]}, 64'hFF44);
    check("be0101_mem_hi", {48'd0, mem[65]}, 64'hFF22);
    run_req(0, 1'b0, 17'h00020, 4'b1111, 32'h0, cyc, rd);
    check("be0101_readback", {32'd0, rd}, 64'hFF22FF44);

    // Read with only the high half enabled
    s1 = lo_ce;
    run_req(0, 1'b0, 17'h00010, 4'b1100, 32'h0, cyc, rd);
    check("be1100_data", {32'd0, rd}, 64'hDEAD0000);
`ifdef SRAM_CTRL_HALFSKIP_EN
    check("be1100_cycle", cyc, 64'd3);
    check("be1100_lo_ce", lo_ce - s1, 64'd0);
`else
    check("be1100_cycle", cyc, 64'd6);
    check("be1100_lo_ce", lo_ce - s1, 64'd3);
`endif

    // Reset during the low strobe of a write
    run_req(0, 1'b1, 17'h00030, 4'b1111, 32'h12345678, cyc, rd);
    check("pre30_cycle", cyc, 64'd6);
    @(posedge clock); #1;
    req_we    = 1'b1;
    req_addr  = 17'h00030;
    req_be    = 4'b1111;
    req_wdata = 32'hCAFEF00D;
    req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    check("abort_in_strobe", {63'd0, sram_we_n}, 64'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    check("abort_strobes", {59'd0, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n},
          64'h1f);
    check("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("abort_ready_in_reset", {63'd0, req_ready}, 64'd0);
    reset = 1'b0;
    #1;
    check("abort_ready_after", {63'd0, req_ready}, 64'd1);
    rv = 0;
    repeat (8) begin
      @(posedge clock); #1;
      if (rsp_valid) rv++;
    end
    check("abort_no_rsp", rv, 64'd0);
    check("abort_hi_unwritten", {48'd0, mem[97]}, 64'h1234);
    run_req(0, 1'b0, 17'h00030, 4'b1111, 32'h0, cyc, rd);
    check("abort_readback_hi", {48'd0, rd[31:16]}, 64'h1234);

    // Back-to-back with req_valid held high
    s1 = both_low;
    req_we   = 1'b0;
    req_addr = 17'h00010;
    req_be   = 4'b1111;
    @(posedge clock); #1;
    req_valid = 1'b1;
    for (int i = 0; i < 22; i++) begin
      if (req_ready) acc.push_back(i);
      @(posedge clock); #1;
    end
    req_valid = 1'b0;
    check("b2b_accepts", acc.size(), 64'd4);
    if (acc.size() >= 3) begin
      check("b2b_gap1", acc[1] - acc[0], 64'd7);
      check("b2b_gap2", acc[2] - acc[1], 64'd7);
    end
    repeat (8) @(posedge clock);
    #1;
    check("b2b_rdata", {32'd0, rsp_rdata}, 64'hDEADBEEF);
    check("b2b_strobe_overlap", both_low - s1, 64'd0);

    // Three-cycle strobe instance
    s1 = we3_low;
    s2 = we3_falls;
    run_req(1, 1'b1, 17'h00008, 4'b1111, 32'hA5A55A5A, cyc, rd);
    check("s3_wr_cycle", cyc, 64'd10);
    check("s3_we_low_cycles", we3_low - s1, 64'd6);
    check("s3_we_falls", we3_falls - s2, 64'd2);
    check("s3_mem_lo", {48'd0, mem3[16]}, 64'h5A5A);
    check("s3_mem_hi", {48'd0, mem3[17]}, 64'hA5A5);
    run_req(1, 1'b0, 17'h00008, 4'b1111, 32'h0, cyc, rd);
    check("s3_rd_cycle", cyc, 64'd10);
    check("s3_rd_data", {32'd0, rd}, 64'hA5A55A5A);
    check("s3_stability", stab3_bad, 64'd0);

    check("never_both_low", both_low, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
